// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment codes ordered {a,b,c,d,e,f,g}.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam seg7_t SEG_DASH  = 7'b1111110;

  localparam seg7_t SEG_LUT [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder with blanking and dash for non-BCD.
import seg7_pkg::*;

module seg7_decode (
  input  logic [3:0] bcd,
  input  logic       blank,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else if (bcd <= 4'd9) begin
      seg = SEG_LUT[bcd];
    end
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode display driver: slot divider, digit index, double-buffered
// digit/dp store swapped at frame wrap, leading-zero mask and registered pin outputs.
import seg7_pkg::*;

module seven_seg_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_COUNT  = 100000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_lz,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     AN,
  output logic                      frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = $clog2(DIV_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(DIV_COUNT - 1);

  logic [DIV_W-1:0]          div_cnt;
  logic [IDX_W-1:0]          idx;
  logic [4*NUM_DIGITS-1:0]   staging_digits;
  logic [NUM_DIGITS-1:0]     staging_dp;
  logic [4*NUM_DIGITS-1:0]   shadow_digits;
  logic [NUM_DIGITS-1:0]     shadow_dp;
  logic                      pending;

  logic                      tick;
  logic                      wrap;
  logic                      transfer;
  logic [3:0]                shadow_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]     an_next;
  logic [NUM_DIGITS-1:0]     blank_vec;
  logic                      all_zero;
  seg7_t                     seg_next;

  assign tick     = en && (div_cnt == DIV_MAX);
  assign wrap     = tick && (idx == LAST_IDX);
  assign transfer = wrap && pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end else if (en) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // A load coinciding with the swap keeps pending set so the new value shows a frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_digits <= '0;
      staging_dp     <= '0;
      shadow_digits  <= '0;
      shadow_dp      <= '0;
      pending        <= 1'b0;
    end else begin
      if (load) begin
        staging_digits <= digits;
        staging_dp     <= dp_in;
      end
      if (transfer) begin
        shadow_digits <= staging_digits;
        shadow_dp     <= staging_dp;
      end
      if (load) begin
        pending <= 1'b1;
      end else if (transfer) begin
        pending <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign shadow_digit[gi] = shadow_digits[gi*4 +: 4];
      assign an_next[gi]      = ~(idx == IDX_W'(gi));
    end
  endgenerate

  // Walk from the most significant digit down; digit 0 always stays visible.
  always_comb begin
    all_zero  = 1'b1;
    blank_vec = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero     = all_zero & (shadow_digit[i] == 4'd0);
      blank_vec[i] = blank_lz & all_zero;
    end
  end

  seg7_decode u_decode (
    .bcd   (shadow_digit[idx]),
    .blank (blank_vec[idx]),
    .seg   (seg_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      AN         <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_next;
      dp         <= ~shadow_dp[idx];
      AN         <= en ? an_next : '1;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for the 4-digit scan driver with a 4-clock digit slot.
module tb_seven_seg_scan_driver;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] SD = 7'b1111110;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  AN;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.NUM_DIGITS(4), .DIV_COUNT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .AN         (AN),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_frame();
    int  n = 0;
    logic found = 1'b0;
    while (!found && n < 200) begin
      @(negedge clk);
      n++;
      if (frame_done === 1'b1) found = 1'b1;
    end
    check("wait_frame", {31'd0, found}, 32'd1);
  endtask

  // Starts right after frame_done was sampled; checks 16 slot samples and ends on the next
  // frame_done. Optional loads are pulsed so they are seen at the posedge after sample la/lb.
  task automatic check_frame(input string tag, input logic [27:0] exp_segs, input logic [3:0] exp_dp,
                             input int la, input logic [15:0] va, input logic [3:0] da,
                             input int lb, input logic [15:0] vb, input logic [3:0] db);
    int mism = 0;
    for (int k = 0; k < 16; k++) begin
      int d;
      logic [3:0] exp_an;
      @(negedge clk);
      d = k / 4;
      exp_an = ~(4'b0001 << d);
      if (AN !== exp_an || seg !== exp_segs[d*7 +: 7] || dp !== exp_dp[d] ||
          frame_done !== (k == 15)) begin
        mism++;
        $display("FAIL %s k=%0d: AN=%b seg=%b dp=%b fd=%b expected AN=%b seg=%b dp=%b fd=%0d",
                 tag, k, AN, seg, dp, frame_done, exp_an, exp_segs[d*7 +: 7], exp_dp[d], (k == 15));
      end
      load = 1'b0;
      if (k == la) begin load = 1'b1; digits = va; dp_in = da; end
      if (k == lb) begin load = 1'b1; digits = vb; dp_in = db; end
    end
    load = 1'b0;
    tests++;
    if (mism != 0) fails++;
    $display("[TB] frame %s: %0d mismatching samples", tag, mism);
  endtask

  initial begin
    // Reset held
    repeat (3) @(negedge clk);
    check("rst_seg", {25'd0, seg}, {25'd0, SB});
    check("rst_dp", {31'd0, dp}, 32'd1);
    check("rst_an", {28'd0, AN}, 32'hF);
    check("rst_fd", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_an", {28'd0, AN}, 32'hE);

    // Scan of 4321
    load = 1'b1; digits = 16'h4321; dp_in = 4'h0;
    @(negedge clk);
    load = 1'b0;
    wait_frame();
    check_frame("scan4321", {S4, S3, S2, S1}, 4'hF, 3, 16'h1111, 4'h0, -1, 16'h0, 4'h0);
    // Tear-free: mid-frame load must not disturb the frame on display
    check_frame("tear1111", {S1, S1, S1, S1}, 4'hF, 6, 16'h2222, 4'h0, -1, 16'h0, 4'h0);
    check_frame("next2222", {S2, S2, S2, S2}, 4'hF, 5, 16'h4444, 4'h0, 14, 16'h3333, 4'h0);
    // Load on the wrap tick is deferred by a frame
    check_frame("defer4444", {S4, S4, S4, S4}, 4'hF, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    check_frame("late3333", {S3, S3, S3, S3}, 4'hF, 3, 16'h00A0, 4'h0, -1, 16'h0, 4'h0);
    // Leading-zero blanking and dash
    blank_lz = 1'b1;
    check_frame("lz_on", {SB, SB, SD, S0}, 4'hF, 2, 16'h00A0, 4'b0101, -1, 16'h0, 4'h0);
    blank_lz = 1'b0;
    check_frame("lz_off_dp", {S0, S0, SD, S0}, 4'b1010, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    blank_lz = 1'b1;
    check_frame("dp_blank", {SB, SB, SD, S0}, 4'b1010, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // Enable freeze at idx 2 after one displayed cycle of that slot
    repeat (9) @(negedge clk);
    check("en_pre_an", {28'd0, AN}, 32'hB);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("en_off_an", {28'd0, AN}, 32'hF);
      check("en_off_fd", {31'd0, frame_done}, 32'd0);
    end
    en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("en_resume_an", {28'd0, AN}, (k < 3) ? 32'hB : 32'h7);
      check("en_resume_fd", {31'd0, frame_done}, (k == 6) ? 32'd1 : 32'd0);
    end
    check_frame("after_en", {SB, SB, SD, S0}, 4'b1010, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // Mid-frame reset drops the pending load
    load = 1'b1; digits = 16'h1234; dp_in = 4'hF;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_seg", {25'd0, seg}, {25'd0, SB});
    check("mrst_dp", {31'd0, dp}, 32'd1);
    check("mrst_an", {28'd0, AN}, 32'hF);
    check("mrst_fd", {31'd0, frame_done}, 32'd0);
    repeat (3) @(negedge clk);
    check("mrst_hold_an", {28'd0, AN}, 32'hF);
    rst_n = 1'b1;
    blank_lz = 1'b0;
    @(negedge clk);
    check("mrst_rel_an", {28'd0, AN}, 32'hE);
    wait_frame();
    check_frame("post_rst", {S0, S0, S0, S0}, 4'hF, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
